// File: rtl/arb_mux_n_1.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux_n_1
// Purpose  : N-to-1 arbitrating multiplexer with a registered output stage.
//            One channel is granted per cycle, either round-robin (MODE 0)
//            or fixed priority, lowest index first (MODE 1).
//            The selected word and its channel index are registered with
//            a one-cycle latency. Full throughput is sustained because the
//            output register can reload in the same cycle it is drained.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            in_valid   - [N] per-channel request
//            in_data    - [N*WIDTH] packed channel data, channel i at i*WIDTH
//            in_ready   - [N] per-channel accept (one-hot or zero)
//            out_valid  - output register holds a word
//            out_data   - [WIDTH] registered selected word
//            out_sel    - [SW] registered index of the supplying channel
//            out_ready  - downstream accept
// Revision : 1.0 - initial release
// ============================================================================
module arb_mux_n_1 #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_sel,
  input  logic                 out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SW-1:0]    r_out_sel;
  logic [SW-1:0]    r_ptr;

  logic             w_load_en;
  logic             w_any;
  logic [N-1:0]     w_grant;
  logic [SW-1:0]    w_gidx;
  logic [SW-1:0]    w_ptr_nxt;
  logic [WIDTH-1:0] w_sel_data;

  // The output register may accept a new word when empty or being drained.
  assign w_load_en = !r_out_valid || out_ready;

  // Search N positions starting at the pointer (or at 0 in fixed priority);
  // the first requesting channel wins. The index wraps explicitly so that
  // non-power-of-two N never produces an out-of-range channel.
  always_comb begin : p_grant
    int k;
    w_grant = '0;
    w_gidx  = '0;
    w_any   = 1'b0;
    k       = 0;
    for (int j = 0; j < N; j++) begin
      k = (MODE == 1) ? j : (int'(r_ptr) + j);
      if (k >= N) begin
        k = k - N;
      end
      if (!w_any && in_valid[k[SW-1:0]]) begin
        w_any               = 1'b1;
        w_grant[k[SW-1:0]]  = 1'b1;
        w_gidx              = k[SW-1:0];
      end
    end
  end

  // One-hot AND-OR data mux keeps in_ready independent of in_data.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N; i++) begin
      w_sel_data = w_sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
    end
  end

  always_comb begin
    if (int'(w_gidx) == N - 1) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_gidx + SW'(1);
    end
  end

  assign in_ready = w_grant & {N{w_load_en}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_gidx;
        if (MODE == 0) begin
          r_ptr <= w_ptr_nxt;
        end
      end else begin
        // Drained with nothing to load: data and index keep their last value.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux_n_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_mux_n_1
// Purpose  : Self-checking bench for arb_mux_n_1. Three instances share one
//            stimulus: dut0 N=4 round-robin, dut1 N=4 fixed priority,
//            dut2 N=3 round-robin (uses the low 3 channels). A behavioural
//            model tracks each instance; literal checks pin key sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_mux_n_1;

  logic         clk;
  logic         rst_n;
  logic [3:0]   vin;
  logic [127:0] din;
  logic         ordy;

  logic         d_ov  [3];
  logic [31:0]  d_od  [3];
  logic [1:0]   d_os  [3];
  logic [3:0]   d_rdy [3];
  logic [3:0]   rdy_a;
  logic [3:0]   rdy_b;
  logic [2:0]   rdy_c;

  assign d_rdy[0] = rdy_a;
  assign d_rdy[1] = rdy_b;
  assign d_rdy[2] = {1'b0, rdy_c};

  arb_mux_n_1 #(.WIDTH(32), .N(4), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin), .in_data(din),
    .in_ready(rdy_a), .out_valid(d_ov[0]), .out_data(d_od[0]),
    .out_sel(d_os[0]), .out_ready(ordy));

  arb_mux_n_1 #(.WIDTH(32), .N(4), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin), .in_data(din),
    .in_ready(rdy_b), .out_valid(d_ov[1]), .out_data(d_od[1]),
    .out_sel(d_os[1]), .out_ready(ordy));

  arb_mux_n_1 #(.WIDTH(32), .N(3), .MODE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin[2:0]), .in_data(din[95:0]),
    .in_ready(rdy_c), .out_valid(d_ov[2]), .out_data(d_od[2]),
    .out_sel(d_os[2]), .out_ready(ordy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          mn    [3] = '{4, 4, 3};
  int          mmode [3] = '{0, 1, 0};
  logic        m_ov  [3];
  logic [31:0] m_od  [3];
  int          m_os  [3];
  int          m_ptr [3];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", nm, k, act, exp, $time);
    else
      n_pass++;
  endtask

  // Index of the channel that must be granted, or -1 if none requests.
  function automatic int gnt(input int k, input logic [3:0] v);
    for (int j = 0; j < mn[k]; j++) begin
      int idx;
      idx = (mmode[k] == 1) ? j : (m_ptr[k] + j) % mn[k];
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ov[k] = 1'b0; m_od[k] = '0; m_os[k] = 0; m_ptr[k] = 0;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      chk("out_valid", k, 64'(d_ov[k]), 64'(m_ov[k]));
      chk("out_data",  k, 64'(d_od[k]), 64'(m_od[k]));
      chk("out_sel",   k, 64'(d_os[k]), 64'(m_os[k]));
    end
  endtask

  // One cycle: drive, check in_ready, clock, advance model, check registers.
  task automatic step(input logic [3:0] v, input logic [127:0] d, input logic r);
    int   g   [3];
    logic le  [3];
    vin = v; din = d; ordy = r;
    #1;
    for (int k = 0; k < 3; k++) begin
      logic [3:0] er;
      g[k]  = gnt(k, v);
      le[k] = !m_ov[k] || r;
      er    = (le[k] && g[k] >= 0) ? 4'(1 << g[k]) : 4'b0;
      chk("in_ready", k, 64'(d_rdy[k]), 64'(er));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (le[k]) begin
        if (g[k] >= 0) begin
          m_ov[k] = 1'b1;
          m_od[k] = d[g[k]*32 +: 32];
          m_os[k] = g[k];
          if (mmode[k] == 0) m_ptr[k] = (g[k] + 1) % mn[k];
        end else begin
          m_ov[k] = 1'b0;
        end
      end
    end
    #1;
    check_outputs();
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", k, 64'(d_ov[k]), 64'h0);
      chk("rst_data",  k, 64'(d_od[k]), 64'h0);
      chk("rst_sel",   k, 64'(d_os[k]), 64'h0);
    end
    @(posedge clk);
    #1;
    check_outputs();
    #2;
    rst_n = 1'b1;
  endtask

  logic [127:0] dA;
  logic [127:0] dS;
  logic [127:0] dS2;

  initial begin
    rst_n = 1'b0; vin = '0; din = '0; ordy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    #3;
    rst_n = 1'b1;

    // Round-robin rotation, all channels requesting, no bubbles.
    dA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    for (int i = 0; i < 6; i++) begin
      step(4'b1111, dA, 1'b1);
      chk("rr_sel",   0, 64'(d_os[0]), 64'(i % 4));
      chk("rr_data",  0, 64'(d_od[0]), 64'(32'hA0 + (i % 4)));
      chk("rr_valid", 0, 64'(d_ov[0]), 64'h1);
      chk("fp_sel",   1, 64'(d_os[1]), 64'h0);
      chk("n3_sel",   2, 64'(d_os[2]), 64'(i % 3));
    end

    // Fixed priority never reaches channel 3 while channel 1 requests.
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, dA, 1'b1);
      chk("fp_sel1", 1, 64'(d_os[1]), 64'h1);
    end

    // Stall with a held word.
    dS  = {32'h3, 32'h2, 32'h1, 32'h55};
    dS2 = {32'h3, 32'h2, 32'h1, 32'h77};
    step(4'b0001, dS, 1'b1);
    chk("stall_load", 0, 64'(d_od[0]), 64'h55);
    for (int i = 0; i < 3; i++) begin
      vin = 4'b0001; din = dS2; ordy = 1'b0;
      #1;
      chk("stall_rdy", 0, 64'(d_rdy[0]), 64'h0);
      step(4'b0001, dS2, 1'b0);
      chk("stall_data", 0, 64'(d_od[0]), 64'h55);
    end
    step(4'b0001, dS2, 1'b1);
    chk("unstall_data", 0, 64'(d_od[0]), 64'h77);

    // Idle drain: valid drops, data and pointer hold (pointer is 1 here).
    step(4'b0000, dS2, 1'b1);
    chk("idle_valid", 0, 64'(d_ov[0]), 64'h0);
    chk("idle_data",  0, 64'(d_od[0]), 64'h77);
    step(4'b1111, dA, 1'b1);
    chk("idle_ptr", 0, 64'(d_os[0]), 64'h1);

    // Reset with word held and pointer at 2; pointer must restart at 0.
    async_reset();
    step(4'b1111, dA, 1'b1);
    chk("post_rst_sel", 0, 64'(d_os[0]), 64'h0);
    chk("post_rst_sel", 2, 64'(d_os[2]), 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      step(4'($urandom), {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb_mux_n_1.md
ARB_MUX_N_1 -- requirements
Module: arb_mux_n_1

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits; legal range 1..64.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..8.
REQ-003 Parameter MODE, default 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 Parameter SW = max(1, clog2(N)), derived, width of channel index fields; not to be overridden.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, declared first as follows.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous reset, active-low.
REQ-008 in_valid  input  N  per-channel request; bit i belongs to channel i.
REQ-009 in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 in_ready  output  N  per-channel accept; channel i is transferred when in_valid[i] and in_ready[i] are both 1 at a rising edge.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_data  output  WIDTH  registered selected word.
REQ-013 out_sel  output  SW  registered index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accept; the word is transferred when out_valid and out_ready are both 1 at a rising edge.

Function
REQ-015 load_en SHALL be (!out_valid || out_ready), combinational.
REQ-016 The grant SHALL be one-hot or zero, combinational from in_valid and ptr; at most one in_ready bit SHALL be 1.
REQ-017 MODE 0: grant goes to the first asserted in_valid bit, searching from index ptr upward and wrapping N-1 -> 0.
REQ-018 MODE 1: grant goes to the lowest-index asserted in_valid bit; ptr is held at 0 and ignored.
REQ-019 in_ready SHALL equal grant & {N{load_en}}; in_ready SHALL NOT depend combinationally on in_data.
REQ-020 On a transfer from channel g: out_data <= channel g data, out_sel <= g, out_valid <= 1, all with 1-cycle latency.
REQ-021 On a transfer, MODE 0: ptr <= (g+1) mod N; g = N-1 wraps ptr to 0.
REQ-022 When load_en=1 and in_valid=0: out_valid <= 0; out_data and out_sel hold their values.
REQ-023 When load_en=0 (stall): out_valid, out_data, out_sel and ptr SHALL hold, and in_ready SHALL be all-zero.
REQ-024 Simultaneous output drain and input load in one cycle SHALL sustain a throughput of 1 word/cycle with no bubble.
REQ-025 A channel deasserting in_valid before it is granted SHALL not be transferred, and ptr SHALL NOT change.
REQ-026 With N not a power of 2, ptr SHALL never take values >= N.

Reset
REQ-027 On rst_n=0, asynchronously: out_valid=0, out_data=0, out_sel=0, ptr=0; in_ready follows from out_valid=0 and in_valid.
REQ-028 Reset asserted while out_valid=1 SHALL discard the held word; no transfer is reported for it.
REQ-029 The first rising edge after rst_n rises SHALL be able to perform a transfer.

Verification
REQ-030 N=4, MODE 0, out_ready=1, in_valid=4'b1111 held, channel i data = 32'hA0+i -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, out_data 32'hA0,A1,A2,A3,A0,A1, no bubbles.
REQ-031 N=4, MODE 1, in_valid=4'b1010, out_ready=1 -> out_sel=1 every cycle; channel 3 is never granted while channel 1 is valid.
REQ-032 Stall: out_valid=1 holding 32'h55, out_ready=0 for 3 cycles with in_valid=4'b0001 -> in_ready=0, out_data stays 32'h55; on out_ready=1, next cycle out_data = channel 0 data.
REQ-033 Idle: out_valid=1, out_ready=1, in_valid=0 -> next cycle out_valid=0, out_data unchanged, ptr unchanged.
REQ-034 N=3, MODE 0: grant channel 2 -> ptr wraps to 0; next grant with in_valid=3'b111 is channel 0.
REQ-035 Reset mid-stream: rst_n=0 while out_valid=1 and ptr=2 -> out_valid, out_data, out_sel and ptr all 0 immediately, without waiting for a clock edge.
